fwd_regfile: RTL and testbench
==============================

# fwd_regfile

Parametrised register file with integrated operand forwarding, load-use stall detection and a registered ID/EX operand latch for the pipelined MIPS CPU. It sits in the decode stage. It replaces the single-source write-back forwarding path with a bypass network fed from the EX, MEM and WB stages, supports a configurable number of read ports, and produces bubble and stall control for the pipeline.

## Interface
Parameters:
- DATA_W, 32, register and operand width
- ADDR_W, 5, register address width; register count is 2**ADDR_W
- NUM_RD, 2, number of read ports
- CNT_W, 16, stall counter width

Ports (packing: port i occupies `[i*ADDR_W +: ADDR_W]` or `[i*DATA_W +: DATA_W]`):
- CLK  in  1  clock, all state on rising edge
- RESET  in  1  asynchronous, active-high reset
- id_valid  in  1  decode-stage instruction valid
- id_raddr  in  NUM_RD*ADDR_W  source register addresses
- id_ruse  in  NUM_RD  per-port "operand actually used" mask (stall qualification only)
- ex_wen, ex_is_load  in  1 each  EX-stage instruction writes a register / is a load
- ex_waddr  in  ADDR_W;  ex_wdata  in  DATA_W  EX-stage destination and ALU result
- mem_wen  in  1;  mem_waddr  in  ADDR_W;  mem_wdata  in  DATA_W  MEM-stage result (load data already resolved)
- wb_wen  in  1;  wb_waddr  in  ADDR_W;  wb_wdata  in  DATA_W  write-back port
- flush  in  1  squash the instruction entering EX
- stall  out  1  load-use hazard; upstream holds PC and IF/ID
- op_valid  out  1  registered: operands in op_data belong to a live instruction
- op_data  out  NUM_RD*DATA_W  registered operands
- op_src  out  2*NUM_RD  registered per-port source: 0 array, 1 WB, 2 MEM, 3 EX
- stall_count  out  CNT_W  saturating count of stall cycles

## Operation
- Storage: 2**ADDR_W x DATA_W. Register 0 reads as 0 and is never written.
- Write: on a rising edge with wb_wen=1 and wb_waddr≠0, reg[wb_waddr] ← wb_wdata.
- Per-port operand select, in priority order:
  - raddr = 0 → 0, src 0.
  - ex_wen and !ex_is_load and ex_waddr = raddr → ex_wdata, src 3.
  - mem_wen and mem_waddr = raddr → mem_wdata, src 2.
  - wb_wen and wb_waddr = raddr → wb_wdata, src 1 (write-through).
  - Otherwise array, src 0.
- Load-use hazard: stall = id_valid and ex_wen and ex_is_load and ex_waddr≠0 and, for any port i, id_ruse[i] and raddr[i] = ex_waddr.
  - A load match on a port with id_ruse=0 does not stall.
  - When stall=0, a load in EX is skipped in the priority list; selection falls through to MEM, WB, then array.
- Operand latch, on each rising edge:
  - flush=1 → op_valid ← 0; op_data and op_src hold. flush has priority over stall.
  - Else stall=1 → op_valid ← 0 (bubble); op_data and op_src hold.
  - Else op_valid ← id_valid, op_data ← selected values, op_src ← selects.
- stall_count increments on each edge where stall=1. It saturates at 2**CNT_W−1.

## Timing
- RESET asserted: asynchronously clears all registers to 0, and sets op_valid=0, op_data=0, op_src=0, stall_count=0. stall is forced to 0 while RESET=1.
- Forwarding and stall are combinational from the inputs in the same cycle. Operands appear on op_data one edge later, giving a latency of 1 cycle.
- A load-use pair stalls for exactly one cycle. On the next cycle the load sits in MEM and is forwarded from mem_wdata, src 2.
- A WB write and a read of the same address in the same cycle return wb_wdata, not the stale array value.
- Simultaneous EX, MEM and WB writes to the same address: the EX value wins. The array still takes the WB value on the edge.
- RESET released mid-stream: the first edge after deassertion behaves as normal operation with an empty array.

## Test plan
- Reset: hold RESET, then write r5=0x1234 via WB and read r5 next cycle → op_data=0x1234, src 0. Read r0 after a WB write of 0xFFFF to r0 → 0.
- Priority: ex r3=0xA, mem r3=0xB, wb r3=0xC, read r3 → op_data=0xA, src 3. Drop ex_wen → 0xB, src 2. Also drop mem_wen → 0xC, src 1. Next cycle with no writers → 0xC, src 0.
- Load-use: ex load to r7, id reads r7 with ruse=1 → stall=1 for one cycle, op_valid=0, stall_count=1. Next cycle mem r7=0x55 → op_data=0x55, src 2, op_valid=1.
- Unused port: same as load-use but id_ruse=0 for the matching port → stall=0 and no bubble.
- Flush during stall: stall=1 and flush=1 → op_valid=0 and op_data unchanged. Check NUM_RD=3, ADDR_W=4 with three distinct forward sources on three ports.
- Saturation: CNT_W=2 with 5 consecutive stalls → stall_count=3. Assert RESET mid-stall → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fwd_regfile_if.sv
// Decode-stage operand bus: source addresses, EX/MEM/WB bypass feeds, flush in; stall and ID/EX operands out.
// master drives the pipeline side, slave is the register file.
interface fwd_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int CNT_W  = 16
);
  logic                     id_valid;
  logic [NUM_RD*ADDR_W-1:0] id_raddr;
  logic [NUM_RD-1:0]        id_ruse;
  logic                     ex_wen;
  logic                     ex_is_load;
  logic [ADDR_W-1:0]        ex_waddr;
  logic [DATA_W-1:0]        ex_wdata;
  logic                     mem_wen;
  logic [ADDR_W-1:0]        mem_waddr;
  logic [DATA_W-1:0]        mem_wdata;
  logic                     wb_wen;
  logic [ADDR_W-1:0]        wb_waddr;
  logic [DATA_W-1:0]        wb_wdata;
  logic                     flush;
  logic                     stall;
  logic                     op_valid;
  logic [NUM_RD*DATA_W-1:0] op_data;
  logic [2*NUM_RD-1:0]      op_src;
  logic [CNT_W-1:0]         stall_count;

  modport master (
    output id_valid, id_raddr, id_ruse,
    output ex_wen, ex_is_load, ex_waddr, ex_wdata,
    output mem_wen, mem_waddr, mem_wdata,
    output wb_wen, wb_waddr, wb_wdata, flush,
    input  stall, op_valid, op_data, op_src, stall_count
  );

  modport slave (
    input  id_valid, id_raddr, id_ruse,
    input  ex_wen, ex_is_load, ex_waddr, ex_wdata,
    input  mem_wen, mem_waddr, mem_wdata,
    input  wb_wen, wb_waddr, wb_wdata, flush,
    output stall, op_valid, op_data, op_src, stall_count
  );
endinterface

// File: rtl/fwd_regfile.sv
// Decode-stage register file with EX/MEM/WB bypass, load-use stall detection and a registered ID/EX operand latch.
// Latency 1 cycle to op_data; stall holds upstream and bubbles op_valid, flush squashes the EX entry.
module fwd_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int CNT_W  = 16
) (
  input  logic         CLK,
  input  logic         RESET,
  fwd_regfile_if.slave bus
);
  localparam int NUM_REGS = 2 ** ADDR_W;

  localparam logic [1:0] SRC_ARR = 2'd0;
  localparam logic [1:0] SRC_WB  = 2'd1;
  localparam logic [1:0] SRC_MEM = 2'd2;
  localparam logic [1:0] SRC_EX  = 2'd3;

  logic [DATA_W-1:0]        rf [NUM_REGS];
  logic [NUM_RD*DATA_W-1:0] sel_data;
  logic [2*NUM_RD-1:0]      sel_src;
  logic [NUM_RD-1:0]        port_hit;
  logic                     load_use;

  logic                     op_valid_q;
  logic [NUM_RD*DATA_W-1:0] op_data_q;
  logic [2*NUM_RD-1:0]      op_src_q;
  logic [CNT_W-1:0]         stall_count_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int r = 0; r < NUM_REGS; r++) rf[r] <= '0;
    end else if (bus.wb_wen && bus.wb_waddr != '0) begin
      rf[bus.wb_waddr] <= bus.wb_wdata;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_port
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] pdata;
    logic [1:0]        psrc;

    assign ra = bus.id_raddr[g*ADDR_W +: ADDR_W];

    // A load in EX has no result yet, so it is skipped and lower stages are searched.
    always_comb begin
      pdata = rf[ra];
      psrc  = SRC_ARR;
      if (ra == '0) begin
        pdata = '0;
        psrc  = SRC_ARR;
      end else if (bus.ex_wen && !bus.ex_is_load && bus.ex_waddr == ra) begin
        pdata = bus.ex_wdata;
        psrc  = SRC_EX;
      end else if (bus.mem_wen && bus.mem_waddr == ra) begin
        pdata = bus.mem_wdata;
        psrc  = SRC_MEM;
      end else if (bus.wb_wen && bus.wb_waddr == ra) begin
        pdata = bus.wb_wdata;
        psrc  = SRC_WB;
      end
    end

    assign sel_data[g*DATA_W +: DATA_W] = pdata;
    assign sel_src[g*2 +: 2]            = psrc;
    assign port_hit[g]                  = bus.id_ruse[g] && (ra == bus.ex_waddr);
  end

  assign load_use = !RESET && bus.id_valid && bus.ex_wen && bus.ex_is_load &&
                    (bus.ex_waddr != '0) && (|port_hit);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      op_valid_q <= 1'b0;
      op_data_q  <= '0;
      op_src_q   <= '0;
    end else if (bus.flush || load_use) begin
      op_valid_q <= 1'b0;
    end else begin
      op_valid_q <= bus.id_valid;
      op_data_q  <= sel_data;
      op_src_q   <= sel_src;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stall_count_q <= '0;
    end else if (load_use && stall_count_q != '1) begin
      stall_count_q <= stall_count_q + CNT_W'(1);
    end
  end

  assign bus.stall       = load_use;
  assign bus.op_valid    = op_valid_q;
  assign bus.op_data     = op_data_q;
  assign bus.op_src      = op_src_q;
  assign bus.stall_count = stall_count_q;
endmodule

// File: tb/tb_fwd_regfile.sv
// Bench for fwd_regfile: directed scenarios on a 2-port and a 3-port/4-bit-address/2-bit-counter instance,
// then randomized traffic on the 2-port instance against a behavioural model.
module tb_fwd_regfile;
  logic CLK;
  logic RESET;
  int   checks;
  int   errors;

  fwd_regfile_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .CNT_W(16)) ifa ();
  fwd_regfile_if #(.DATA_W(32), .ADDR_W(4), .NUM_RD(3), .CNT_W(2))  ifb ();

  fwd_regfile #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .CNT_W(16)) dut_a (.CLK(CLK), .RESET(RESET), .bus(ifa));
  fwd_regfile #(.DATA_W(32), .ADDR_W(4), .NUM_RD(3), .CNT_W(2))  dut_b (.CLK(CLK), .RESET(RESET), .bus(ifb));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_a();
    ifa.id_valid = 0; ifa.id_raddr = '0; ifa.id_ruse = '0;
    ifa.ex_wen = 0; ifa.ex_is_load = 0; ifa.ex_waddr = '0; ifa.ex_wdata = '0;
    ifa.mem_wen = 0; ifa.mem_waddr = '0; ifa.mem_wdata = '0;
    ifa.wb_wen = 0; ifa.wb_waddr = '0; ifa.wb_wdata = '0; ifa.flush = 0;
  endtask

  task automatic idle_b();
    ifb.id_valid = 0; ifb.id_raddr = '0; ifb.id_ruse = '0;
    ifb.ex_wen = 0; ifb.ex_is_load = 0; ifb.ex_waddr = '0; ifb.ex_wdata = '0;
    ifb.mem_wen = 0; ifb.mem_waddr = '0; ifb.mem_wdata = '0;
    ifb.wb_wen = 0; ifb.wb_waddr = '0; ifb.wb_wdata = '0; ifb.flush = 0;
  endtask

  task automatic test_reset();
    RESET = 1;
    idle_a();
    ifa.id_valid = 1; ifa.ex_wen = 1; ifa.ex_is_load = 1; ifa.ex_waddr = 5'd4;
    ifa.id_raddr = {5'd0, 5'd4}; ifa.id_ruse = 2'b01;
    #1;
    checks++; if (ifa.stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %0b want 0", ifa.stall); end
    checks++; if (ifa.op_valid !== 1'b0) begin errors++; $display("FAIL rst_op_valid got %0b want 0", ifa.op_valid); end
    checks++; if (ifa.op_data !== 64'h0) begin errors++; $display("FAIL rst_op_data got %0h want 0", ifa.op_data); end
    checks++; if (ifa.op_src !== 4'h0) begin errors++; $display("FAIL rst_op_src got %0h want 0", ifa.op_src); end
    checks++; if (ifa.stall_count !== 16'h0) begin errors++; $display("FAIL rst_stall_count got %0d want 0", ifa.stall_count); end
    idle_a();
    step();
    RESET = 0;
    ifa.wb_wen = 1; ifa.wb_waddr = 5'd5; ifa.wb_wdata = 32'h1234;
    step();
    idle_a();
    ifa.id_valid = 1; ifa.id_raddr = {5'd0, 5'd5};
    step();
    checks++; if (ifa.op_data[31:0] !== 32'h1234) begin errors++; $display("FAIL rd_r5_data got %0h want 1234", ifa.op_data[31:0]); end
    checks++; if (ifa.op_src[1:0] !== 2'd0) begin errors++; $display("FAIL rd_r5_src got %0d want 0", ifa.op_src[1:0]); end
    checks++; if (ifa.op_valid !== 1'b1) begin errors++; $display("FAIL rd_r5_valid got %0b want 1", ifa.op_valid); end
    ifa.wb_wen = 1; ifa.wb_waddr = 5'd0; ifa.wb_wdata = 32'hFFFF; ifa.id_raddr = {5'd0, 5'd0};
    step();
    checks++; if (ifa.op_data !== 64'h0) begin errors++; $display("FAIL r0_same_cycle got %0h want 0", ifa.op_data); end
    ifa.wb_wen = 0;
    step();
    checks++; if (ifa.op_data[31:0] !== 32'h0) begin errors++; $display("FAIL r0_after_write got %0h want 0", ifa.op_data[31:0]); end
  endtask

  task automatic test_priority();
    idle_a();
    ifa.id_valid = 1; ifa.id_raddr = {5'd0, 5'd3}; ifa.id_ruse = 2'b01;
    ifa.ex_wen = 1;  ifa.ex_waddr = 5'd3;  ifa.ex_wdata = 32'hA;
    ifa.mem_wen = 1; ifa.mem_waddr = 5'd3; ifa.mem_wdata = 32'hB;
    ifa.wb_wen = 1;  ifa.wb_waddr = 5'd3;  ifa.wb_wdata = 32'hC;
    step();
    checks++; if (ifa.op_data[31:0] !== 32'hA || ifa.op_src[1:0] !== 2'd3) begin errors++; $display("FAIL prio_ex got %0h/%0d want a/3", ifa.op_data[31:0], ifa.op_src[1:0]); end
    ifa.ex_wen = 0;
    step();
    checks++; if (ifa.op_data[31:0] !== 32'hB || ifa.op_src[1:0] !== 2'd2) begin errors++; $display("FAIL prio_mem got %0h/%0d want b/2", ifa.op_data[31:0], ifa.op_src[1:0]); end
    ifa.mem_wen = 0;
    step();
    checks++; if (ifa.op_data[31:0] !== 32'hC || ifa.op_src[1:0] !== 2'd1) begin errors++; $display("FAIL prio_wb got %0h/%0d want c/1", ifa.op_data[31:0], ifa.op_src[1:0]); end
    ifa.wb_wen = 0;
    step();
    checks++; if (ifa.op_data[31:0] !== 32'hC || ifa.op_src[1:0] !== 2'd0) begin errors++; $display("FAIL prio_arr got %0h/%0d want c/0", ifa.op_data[31:0], ifa.op_src[1:0]); end
  endtask

  task automatic test_load_use();
    idle_a();
    ifa.id_valid = 1; ifa.id_raddr = {5'd0, 5'd7}; ifa.id_ruse = 2'b01;
    ifa.ex_wen = 1; ifa.ex_is_load = 1; ifa.ex_waddr = 5'd7;
    #1;
    checks++; if (ifa.stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %0b want 1", ifa.stall); end
    step();
    checks++; if (ifa.op_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble got %0b want 0", ifa.op_valid); end
    checks++; if (ifa.stall_count !== 16'd1) begin errors++; $display("FAIL lu_count got %0d want 1", ifa.stall_count); end
    ifa.ex_wen = 0; ifa.ex_is_load = 0;
    ifa.mem_wen = 1; ifa.mem_waddr = 5'd7; ifa.mem_wdata = 32'h55;
    #1;
    checks++; if (ifa.stall !== 1'b0) begin errors++; $display("FAIL lu_release got %0b want 0", ifa.stall); end
    step();
    checks++; if (ifa.op_data[31:0] !== 32'h55 || ifa.op_src[1:0] !== 2'd2) begin errors++; $display("FAIL lu_fwd got %0h/%0d want 55/2", ifa.op_data[31:0], ifa.op_src[1:0]); end
    checks++; if (ifa.op_valid !== 1'b1) begin errors++; $display("FAIL lu_valid got %0b want 1", ifa.op_valid); end
  endtask

  task automatic test_unused_port();
    idle_a();
    ifa.id_valid = 1; ifa.id_raddr = {5'd7, 5'd2}; ifa.id_ruse = 2'b01;
    ifa.ex_wen = 1; ifa.ex_is_load = 1; ifa.ex_waddr = 5'd7; ifa.ex_wdata = 32'hDEAD;
    #1;
    checks++; if (ifa.stall !== 1'b0) begin errors++; $display("FAIL unused_stall got %0b want 0", ifa.stall); end
    step();
    checks++; if (ifa.op_valid !== 1'b1) begin errors++; $display("FAIL unused_valid got %0b want 1", ifa.op_valid); end
    checks++; if (ifa.op_data[63:32] !== 32'h0 || ifa.op_src[3:2] !== 2'd0) begin errors++; $display("FAIL unused_skip_load got %0h/%0d want 0/0", ifa.op_data[63:32], ifa.op_src[3:2]); end
    checks++; if (ifa.stall_count !== 16'd1) begin errors++; $display("FAIL unused_count got %0d want 1", ifa.stall_count); end
  endtask

  task automatic test_flush();
    idle_a();
    ifa.id_valid = 1; ifa.id_raddr = {5'd0, 5'd3}; ifa.id_ruse = 2'b01;
    ifa.ex_wen = 1; ifa.ex_waddr = 5'd3; ifa.ex_wdata = 32'hAB;
    step();
    checks++; if (ifa.op_data[31:0] !== 32'hAB || ifa.op_valid !== 1'b1) begin errors++; $display("FAIL fl_setup got %0h/%0b want ab/1", ifa.op_data[31:0], ifa.op_valid); end
    ifa.ex_is_load = 1; ifa.ex_wdata = 32'h99; ifa.flush = 1;
    #1;
    checks++; if (ifa.stall !== 1'b1) begin errors++; $display("FAIL fl_stall got %0b want 1", ifa.stall); end
    step();
    checks++; if (ifa.op_valid !== 1'b0 || ifa.op_data[31:0] !== 32'hAB) begin errors++; $display("FAIL fl_hold got %0b/%0h want 0/ab", ifa.op_valid, ifa.op_data[31:0]); end
    checks++; if (ifa.stall_count !== 16'd2) begin errors++; $display("FAIL fl_count got %0d want 2", ifa.stall_count); end
    ifa.ex_wen = 0; ifa.ex_is_load = 0; ifa.mem_wen = 1; ifa.mem_waddr = 5'd3; ifa.mem_wdata = 32'hCD;
    step();
    checks++; if (ifa.op_valid !== 1'b0 || ifa.op_data[31:0] !== 32'hAB || ifa.op_src[1:0] !== 2'd3) begin errors++; $display("FAIL fl_only got %0b/%0h/%0d want 0/ab/3", ifa.op_valid, ifa.op_data[31:0], ifa.op_src[1:0]); end
    idle_a();
  endtask

  task automatic test_three_src();
    idle_b();
    ifb.id_valid = 1; ifb.id_raddr = {4'd3, 4'd2, 4'd1}; ifb.id_ruse = 3'b111;
    ifb.ex_wen = 1;  ifb.ex_waddr = 4'd1;  ifb.ex_wdata = 32'h11;
    ifb.mem_wen = 1; ifb.mem_waddr = 4'd2; ifb.mem_wdata = 32'h22;
    ifb.wb_wen = 1;  ifb.wb_waddr = 4'd3;  ifb.wb_wdata = 32'h33;
    step();
    checks++; if (ifb.op_data !== {32'h33, 32'h22, 32'h11}) begin errors++; $display("FAIL three_data got %0h want 33_22_11", ifb.op_data); end
    checks++; if (ifb.op_src !== 6'b01_10_11) begin errors++; $display("FAIL three_src got %b want 011011", ifb.op_src); end
    ifb.ex_wen = 0; ifb.mem_wen = 0; ifb.wb_wen = 0;
    step();
    checks++; if (ifb.op_data !== {32'h33, 64'h0} || ifb.op_src !== 6'b0) begin errors++; $display("FAIL three_arr got %0h/%b want 33_0_0/0", ifb.op_data, ifb.op_src); end
  endtask

  task automatic test_saturation();
    idle_b();
    ifb.id_valid = 1; ifb.id_raddr = {4'd5, 4'd0, 4'd0}; ifb.id_ruse = 3'b100;
    ifb.ex_wen = 1; ifb.ex_is_load = 1; ifb.ex_waddr = 4'd5;
    for (int k = 0; k < 5; k++) step();
    checks++; if (ifb.stall_count !== 2'd3) begin errors++; $display("FAIL sat_count got %0d want 3", ifb.stall_count); end
    checks++; if (ifb.stall !== 1'b1 || ifb.op_data !== {32'h33, 64'h0}) begin errors++; $display("FAIL sat_hold got %0b/%0h want 1/33_0_0", ifb.stall, ifb.op_data); end
    #2;
    RESET = 1;
    #1;
    checks++; if (ifb.stall !== 1'b0 || ifb.op_valid !== 1'b0) begin errors++; $display("FAIL arst_ctl got %0b/%0b want 0/0", ifb.stall, ifb.op_valid); end
    checks++; if (ifb.op_data !== 96'h0 || ifb.op_src !== 6'h0) begin errors++; $display("FAIL arst_data got %0h/%0h want 0/0", ifb.op_data, ifb.op_src); end
    checks++; if (ifb.stall_count !== 2'd0) begin errors++; $display("FAIL arst_count got %0d want 0", ifb.stall_count); end
    idle_b();
  endtask

  task automatic test_random();
    logic [31:0] m_rf [32];
    logic [31:0] m_data [2];
    logic [1:0]  m_src [2];
    logic [31:0] n_data [2];
    logic [1:0]  n_src [2];
    logic        m_valid;
    logic        e_stall;
    int          m_cnt;
    logic [4:0]  ra;
    RESET = 1;
    idle_a();
    step();
    RESET = 0;
    for (int r = 0; r < 32; r++) m_rf[r] = 32'h0;
    for (int p = 0; p < 2; p++) begin m_data[p] = 32'h0; m_src[p] = 2'd0; end
    m_valid = 0;
    m_cnt = 0;
    for (int n = 0; n < 400; n++) begin
      ifa.id_valid   = ($urandom_range(0, 9) != 0);
      ifa.id_raddr   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      ifa.id_ruse    = 2'($urandom);
      ifa.ex_wen     = 1'($urandom);
      ifa.ex_is_load = ($urandom_range(0, 2) == 0);
      ifa.ex_waddr   = 5'($urandom_range(0, 7));
      ifa.ex_wdata   = $urandom;
      ifa.mem_wen    = 1'($urandom);
      ifa.mem_waddr  = 5'($urandom_range(0, 7));
      ifa.mem_wdata  = $urandom;
      ifa.wb_wen     = 1'($urandom);
      ifa.wb_waddr   = 5'($urandom_range(0, 7));
      ifa.wb_wdata   = $urandom;
      ifa.flush      = ($urandom_range(0, 9) == 0);
      #1;
      e_stall = 0;
      for (int p = 0; p < 2; p++) begin
        ra = ifa.id_raddr[p*5 +: 5];
        if (ifa.id_valid && ifa.ex_wen && ifa.ex_is_load && ifa.ex_waddr != 0 && ifa.id_ruse[p] && ra == ifa.ex_waddr) e_stall = 1;
        if (ra == 0) begin n_data[p] = 0; n_src[p] = 0; end
        else if (ifa.ex_wen && !ifa.ex_is_load && ifa.ex_waddr == ra) begin n_data[p] = ifa.ex_wdata; n_src[p] = 3; end
        else if (ifa.mem_wen && ifa.mem_waddr == ra) begin n_data[p] = ifa.mem_wdata; n_src[p] = 2; end
        else if (ifa.wb_wen && ifa.wb_waddr == ra) begin n_data[p] = ifa.wb_wdata; n_src[p] = 1; end
        else begin n_data[p] = m_rf[ra]; n_src[p] = 0; end
      end
      checks++; if (ifa.stall !== e_stall) begin errors++; $display("FAIL rnd_stall cyc %0d got %0b want %0b", n, ifa.stall, e_stall); end
      if (ifa.flush || e_stall) m_valid = 0;
      else begin
        m_valid = ifa.id_valid;
        for (int p = 0; p < 2; p++) begin m_data[p] = n_data[p]; m_src[p] = n_src[p]; end
      end
      if (e_stall && m_cnt < 65535) m_cnt++;
      if (ifa.wb_wen && ifa.wb_waddr != 0) m_rf[ifa.wb_waddr] = ifa.wb_wdata;
      step();
      checks++; if (ifa.op_valid !== m_valid) begin errors++; $display("FAIL rnd_valid cyc %0d got %0b want %0b", n, ifa.op_valid, m_valid); end
      for (int p = 0; p < 2; p++) begin
        checks++; if (ifa.op_data[p*32 +: 32] !== m_data[p] || ifa.op_src[p*2 +: 2] !== m_src[p]) begin errors++; $display("FAIL rnd_op cyc %0d port %0d got %0h/%0d want %0h/%0d", n, p, ifa.op_data[p*32 +: 32], ifa.op_src[p*2 +: 2], m_data[p], m_src[p]); end
      end
      checks++; if (ifa.stall_count !== 16'(m_cnt)) begin errors++; $display("FAIL rnd_count cyc %0d got %0d want %0d", n, ifa.stall_count, m_cnt); end
    end
    idle_a();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RESET  = 1;
    idle_a();
    idle_b();
    test_reset();
    test_priority();
    test_load_use();
    test_unused_port();
    test_flush();
    test_three_src();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
